// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction-fetch stage
package fetch_pkg;

    localparam int          XLEN_DEF         = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef logic [31:0]         word_t;
    typedef logic [XLEN_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        NOERROR       = 2'd0,
        INSTRACCESS   = 2'd1,
        INSTRMISALIGN = 2'd2
    } fetch_err_t;

    typedef struct packed {
        logic       valid;
        addr_t      pc;
        word_t      raw_instr;
        fetch_err_t error;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD,
        WAIT_FLUSH
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } skid_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - single-entry buffer for a word returned while decode is stalled
module fetch_skid import fetch_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  skid_entry_t load_entry,
    output logic        full,
    output skid_entry_t entry
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (clear) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction-fetch stage: owns the PC, drives the instruction bus, feeds decode
module fetch import fetch_pkg::*; #(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stopd,
    input  logic            stope,
    input  logic            stopm,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            flushde,
    input  logic [XLEN-1:0] flush_pc,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    output fetch_data_t     dataF
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending;
    logic [XLEN-1:0] target;
    logic            running;
    logic            stall;
    logic            br_eff;
    logic            redirect;
    logic            ok;
    logic            skid_load;
    logic            skid_clear;
    logic            skid_full;
    skid_entry_t     skid_entry;

    assign stall    = stopd | stope | stopm;
    assign br_eff   = branch & ~stope & ~stopm;
    assign redirect = flushde | br_eff;
    assign target   = flushde ? flush_pc : branch_pc;

    // running keeps the bus quiet until the first clock after reset release
    assign ireq_valid = running & (((state == FETCH) & (pc[1:0] == 2'b00)) | (state == DISCARD));
    assign ireq_addr  = pc;
    assign ok         = ireq_valid & iresp_data_ok;

    assign skid_load  = (state == FETCH) & ok & ~redirect & stall;
    assign skid_clear = (state == HOLD) & (redirect | ~stall);

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_entry ('{pc: pc, instr: iresp_data}),
        .full       (skid_full),
        .entry      (skid_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pending <= '0;
            running <= 1'b0;
            dataF   <= '0;
        end else begin
            running <= 1'b1;
            // decode advancing or a flush retires the current entry; later writes override
            if (flushde || !stall) dataF.valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (ok) begin
                        if (redirect) begin
                            pc <= target;
                        end else begin
                            pc <= pc + XLEN'(4);
                            if (stall) state <= HOLD;
                            else dataF <= '{valid: 1'b1, pc: pc, raw_instr: iresp_data, error: NOERROR};
                        end
                    end else if (redirect) begin
                        if (ireq_valid) begin
                            pending <= target;
                            state   <= DISCARD;
                        end else begin
                            pc <= target;
                        end
                    end else if (pc[1:0] != 2'b00 && !stall) begin
                        dataF <= '{valid: 1'b1, pc: pc, raw_instr: 32'h0, error: INSTRMISALIGN};
                        state <= WAIT_FLUSH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        dataF <= '{valid: skid_full, pc: skid_entry.pc,
                                   raw_instr: skid_entry.instr, error: NOERROR};
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (ok) begin
                        pc    <= redirect ? target : pending;
                        state <= FETCH;
                    end else if (redirect) begin
                        pending <= target;
                    end
                end
                WAIT_FLUSH: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
